// File: rtl/fpjh_deaggr_rx.sv
// De-aggregating receive parser: splits a packed AXIS super-frame into one realigned packet per sub-frame.
// Build option FPJH_SEQ_CHECK_EN adds fragment-chain sequence checking on seq_err.
module fpjh_deaggr_rx #(
    parameter int DATA_BYTES = 4,
    parameter int MAX_LEN    = 841,
    parameter int LEN_W      = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_axis_tvalid,
    input  logic [8*DATA_BYTES-1:0] s_axis_tdata,
    input  logic [DATA_BYTES-1:0]   s_axis_tkeep,
    input  logic                    s_axis_tlast,
    output logic                    s_axis_tready,
    output logic                    m_axis_tvalid,
    output logic [8*DATA_BYTES-1:0] m_axis_tdata,
    output logic [DATA_BYTES-1:0]   m_axis_tkeep,
    output logic                    m_axis_tlast,
    input  logic                    m_axis_tready,
    output logic [15:0]             o_type,
    output logic [LEN_W-1:0]        o_length,
    output logic [6:0]              o_frag_cnt,
    output logic                    o_frag_done,
    output logic                    o_err_trunc,
    output logic                    err_len,
    output logic                    seq_err,
    output logic [31:0]             frame_cnt
);
    localparam int BB = 2 * DATA_BYTES;
    localparam int CW = $clog2(BB + 1);
    localparam logic [CW-1:0] DB_C  = CW'(DATA_BYTES);
    localparam logic [11:0]   MAX_L = 12'(MAX_LEN);

    typedef enum logic [2:0] {HDR, OPT, PAY, FLUSH_OUT, DROP} state_t;
    state_t state;

    logic [7:0]       buf_q [BB];
    logic [CW-1:0]    cnt_q;
    logic             eof_q;
    logic [LEN_W-1:0] rem_q, len_q;
    logic [15:0]      type_q;
    logic [6:0]       frag_cnt_q;
    logic             frag_done_q;

    logic             push, eof_eff, out_free, clr, hdr_bad;
    logic             hdr_go, hdr_drop, opt_go, opt_trunc, pay_go, pay_trunc, flush_go;
    logic [CW-1:0]    push_n, avail, pop_n, need, beat_n;
    logic [11:0]      hdr_len;
    logic [7:0]       in_b [DATA_BYTES];
    logic [7:0]       cat  [BB];
    logic [7:0]       nbuf [BB];
    logic [8*DATA_BYTES-1:0] beat_data;
    logic [DATA_BYTES-1:0]   beat_keep;

    // Input accepted only when a whole beat fits; a finished super-frame tail must be parsed out first.
    assign s_axis_tready = (state == DROP) ||
                           (state != FLUSH_OUT && !eof_q && cnt_q <= DB_C);
    assign push     = s_axis_tvalid && s_axis_tready;
    assign eof_eff  = eof_q || (push && s_axis_tlast);
    assign out_free = !m_axis_tvalid || m_axis_tready;
    assign avail    = cnt_q + push_n;
    assign need     = (rem_q < LEN_W'(DATA_BYTES)) ? CW'(rem_q) : DB_C;
    assign beat_n   = (state == FLUSH_OUT) ? cnt_q : need;

    always_comb begin
        push_n = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            in_b[i] = s_axis_tdata[8*(DATA_BYTES-1-i) +: 8];
            if (push && s_axis_tkeep[DATA_BYTES-1-i]) push_n = CW'(i + 1);
        end
    end

    // Buffered bytes followed by this cycle's incoming bytes, byte 0 first.
    always_comb begin
        for (int i = 0; i < BB; i++) begin
            cat[i] = 8'h00;
            if (i < int'(cnt_q))
                cat[i] = buf_q[i];
            else if (push && (i - int'(cnt_q)) < DATA_BYTES)
                cat[i] = in_b[i - int'(cnt_q)];
        end
    end

    always_comb begin
        hdr_len   = {cat[0][3:0], cat[1]};
        hdr_bad   = (hdr_len == 12'd0) || (hdr_len > MAX_L);
        hdr_go    = (state == HDR) && (avail >= CW'(4));
        hdr_drop  = (state == HDR) && (avail < CW'(4)) && eof_eff;
        opt_go    = (state == OPT) && (avail != '0);
        opt_trunc = (state == OPT) && (avail == '0) && eof_eff;
        pay_go    = (state == PAY) && out_free && (avail >= need);
        pay_trunc = (state == PAY) && (avail < need) && eof_eff;
        flush_go  = (state == FLUSH_OUT) && out_free;
        pop_n = '0;
        if (hdr_go) pop_n = CW'(4);
        if (opt_go) pop_n = CW'(1);
        if (pay_go) pop_n = need;
        clr = hdr_drop || (hdr_go && hdr_bad) || flush_go || (state == DROP);
        for (int i = 0; i < BB; i++) begin
            nbuf[i] = 8'h00;
            if (!clr && (i + int'(pop_n)) < BB) nbuf[i] = cat[i + int'(pop_n)];
        end
    end

    always_comb begin
        beat_data = '0;
        beat_keep = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (i < int'(beat_n)) begin
                beat_data[8*(DATA_BYTES-1-i) +: 8] = cat[i];
                beat_keep[DATA_BYTES-1-i]          = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= HDR;
            buf_q         <= '{default: 8'h00};
            cnt_q         <= '0;
            eof_q         <= 1'b0;
            rem_q         <= '0;
            len_q         <= '0;
            type_q        <= '0;
            frag_cnt_q    <= '0;
            frag_done_q   <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            o_type        <= '0;
            o_length      <= '0;
            o_frag_cnt    <= '0;
            o_frag_done   <= 1'b0;
            o_err_trunc   <= 1'b0;
            err_len       <= 1'b0;
            frame_cnt     <= '0;
        end else begin
            buf_q   <= nbuf;
            cnt_q   <= clr ? '0 : avail - pop_n;
            err_len <= 1'b0;
            if (clr)
                eof_q <= 1'b0;
            else if (push && s_axis_tlast)
                eof_q <= 1'b1;

            if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
                if (m_axis_tlast && !o_err_trunc) frame_cnt <= frame_cnt + 32'd1;
            end
            // Sidebands travel with each beat so they stay aligned to the packet being presented.
            if (pay_go || flush_go) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= beat_data;
                m_axis_tkeep  <= beat_keep;
                m_axis_tlast  <= flush_go || (rem_q == LEN_W'(need));
                o_err_trunc   <= flush_go;
                o_type        <= type_q;
                o_length      <= len_q;
                o_frag_cnt    <= frag_cnt_q;
                o_frag_done   <= frag_done_q;
            end

            case (state)
                HDR: if (hdr_go) begin
                    len_q       <= LEN_W'(hdr_len);
                    rem_q       <= LEN_W'(hdr_len);
                    type_q      <= {cat[2], cat[3]};
                    frag_cnt_q  <= '0;
                    frag_done_q <= 1'b0;
                    if (hdr_bad) begin
                        err_len <= 1'b1;
                        state   <= eof_eff ? HDR : DROP;
                    end else begin
                        state <= cat[3][0] ? OPT : PAY;
                    end
                end
                OPT: if (opt_go) begin
                    frag_cnt_q  <= cat[0][7:1];
                    frag_done_q <= cat[0][0];
                    state       <= PAY;
                end else if (opt_trunc) begin
                    state <= FLUSH_OUT;
                end
                PAY: if (pay_go) begin
                    rem_q <= rem_q - LEN_W'(need);
                    if (rem_q == LEN_W'(need)) state <= HDR;
                end else if (pay_trunc) begin
                    state <= FLUSH_OUT;
                end
                FLUSH_OUT: if (flush_go) state <= HDR;
                DROP:      if (push && s_axis_tlast) state <= HDR;
                default:   state <= HDR;
            endcase
        end
    end

`ifdef FPJH_SEQ_CHECK_EN
    logic [6:0] exp_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_cnt_q <= '0;
            seq_err   <= 1'b0;
        end else begin
            seq_err <= 1'b0;
            if (opt_go) begin
                seq_err   <= (cat[0][7:1] != exp_cnt_q);
                exp_cnt_q <= cat[0][7:1] + 7'd1;
            end else if (pay_go && rem_q == LEN_W'(need) && type_q[0] && frag_done_q) begin
                exp_cnt_q <= '0;
            end
        end
    end
`else
    assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_fpjh_deaggr_rx.sv
// Directed bench for fpjh_deaggr_rx with DATA_BYTES=4; expected beats are hand-computed per scenario.
module tb_fpjh_deaggr_rx;
    localparam int DB = 4;
    localparam int W  = 8 * DB;
`ifdef FPJH_SEQ_CHECK_EN
    localparam int SEQ_EN = 1;
`else
    localparam int SEQ_EN = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic [W-1:0]  s_data = '0;
    logic [DB-1:0] s_keep = '0;
    logic          s_last = 1'b0;
    logic          s_ready;
    logic          m_valid;
    logic [W-1:0]  m_data;
    logic [DB-1:0] m_keep;
    logic          m_last;
    logic          m_ready = 1'b1;
    logic [15:0]   o_type;
    logic [11:0]   o_length;
    logic [6:0]    o_frag_cnt;
    logic          o_frag_done, o_err_trunc, err_len, seq_err;
    logic [31:0]   frame_cnt;

    always #5 clk = ~clk;

    fpjh_deaggr_rx #(.DATA_BYTES(DB), .MAX_LEN(841), .LEN_W(12)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tvalid(s_valid), .s_axis_tdata(s_data), .s_axis_tkeep(s_keep),
        .s_axis_tlast(s_last), .s_axis_tready(s_ready),
        .m_axis_tvalid(m_valid), .m_axis_tdata(m_data), .m_axis_tkeep(m_keep),
        .m_axis_tlast(m_last), .m_axis_tready(m_ready),
        .o_type(o_type), .o_length(o_length), .o_frag_cnt(o_frag_cnt),
        .o_frag_done(o_frag_done), .o_err_trunc(o_err_trunc),
        .err_len(err_len), .seq_err(seq_err), .frame_cnt(frame_cnt)
    );

    int total = 0;
    int bad   = 0;
    int err_len_n = 0;
    int seq_err_n = 0;
    logic [36:0] rx_q[$];
    logic [36:0] side_q[$];
    logic [36:0] exp_q[$];

    // Monitor: {last, keep, data} and {type, length, frag_cnt, frag_done, err_trunc} per accepted beat
    always @(negedge clk) begin
        if (!rst) begin
            if (m_valid && m_ready) begin
                rx_q.push_back({m_last, m_keep, m_data});
                side_q.push_back({o_type, o_length, o_frag_cnt, o_frag_done, o_err_trunc});
            end
            if (err_len) err_len_n++;
            if (seq_err) seq_err_n++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] keep_mask(input logic [DB-1:0] k);
        logic [W-1:0] m = '0;
        for (int i = 0; i < DB; i++) if (k[i]) m[8*i +: 8] = 8'hFF;
        return m;
    endfunction

    // Caller is aligned to posedge+1; returns at posedge+1 after the handshake.
    task automatic send_beat(input logic [W-1:0] d, input logic [DB-1:0] k, input logic l);
        int n = 0;
        s_valid = 1'b1; s_data = d; s_keep = k; s_last = l;
        @(negedge clk);
        while (!s_ready && n < 200) begin @(negedge clk); n++; end
        if (!s_ready) begin
            total++; bad++;
            $display("FAIL send_timeout got_ready=%0b want=1", s_ready);
        end
        @(posedge clk); #1;
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic wait_rx(input int n, output bit ok);
        int k = 0;
        while (rx_q.size() < n && k < 300) begin @(negedge clk); k++; end
        ok = (rx_q.size() >= n);
        repeat (5) @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic clear_logs();
        rx_q.delete(); side_q.delete(); exp_q.delete();
        err_len_n = 0; seq_err_n = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; m_ready = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({m_valid, m_last, m_keep, m_data} !== '0 || frame_cnt !== 32'd0 || err_len !== 1'b0 ||
            seq_err !== 1'b0 || o_type !== 16'd0 || o_length !== 12'd0 || o_frag_cnt !== 7'd0 ||
            o_frag_done !== 1'b0 || o_err_trunc !== 1'b0) begin
            bad++;
            $display("FAIL reset_values got valid=%0b keep=%h data=%h fc=%0d want all zero",
                     m_valid, m_keep, m_data, frame_cnt);
        end
        @(posedge clk); #1 rst = 1'b0;
        m_ready = 1'b0;
        send_beat(32'h0008_0000, 4'hF, 1'b0);
        send_beat(32'hAABB_CCDD, 4'hF, 1'b0);
        @(negedge clk);
        total++;
        if (m_valid !== 1'b1) begin
            bad++; $display("FAIL pre_reset_valid got=%0b want=1", m_valid);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (m_valid !== 1'b0 || o_length !== 12'd0 || frame_cnt !== 32'd0) begin
            bad++;
            $display("FAIL async_reset got valid=%0b len=%0d fc=%0d want 0/0/0", m_valid, o_length, frame_cnt);
        end
        @(posedge clk); #1 rst = 1'b0; m_ready = 1'b1;
    endtask

    task automatic test_single();
        bit ok;
        logic [36:0] got;
        clear_logs();
        send_beat(32'h0008_0000, 4'hF, 1'b0);
        send_beat(32'h1122_3344, 4'hF, 1'b0);
        send_beat(32'h5566_7788, 4'hF, 1'b1);
        exp_q.push_back({1'b0, 4'hF, 32'h1122_3344});
        exp_q.push_back({1'b1, 4'hF, 32'h5566_7788});
        wait_rx(2, ok);
        total++;
        if (!ok || rx_q.size() != exp_q.size()) begin
            bad++; $display("FAIL single_count got=%0d want=%0d", rx_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                got = {rx_q[i][36:32], rx_q[i][31:0] & keep_mask(exp_q[i][35:32])};
                total++;
                if (got !== exp_q[i]) begin
                    bad++; $display("FAIL single_beat%0d got=%h want=%h", i, got, exp_q[i]);
                end
            end
            total++;
            if (side_q[1] !== {16'h0000, 12'd8, 7'd0, 1'b0, 1'b0}) begin
                bad++; $display("FAIL single_side got=%h want=%h", side_q[1], {16'h0000, 12'd8, 9'd0});
            end
        end
        total++;
        if (frame_cnt !== 32'd1) begin
            bad++; $display("FAIL single_frame_cnt got=%0d want=1", frame_cnt);
        end
    endtask

    task automatic test_packed();
        bit ok;
        logic [36:0] got;
        clear_logs();
        send_beat(32'h0005_0001, 4'hF, 1'b0);
        send_beat(32'h03A1_A2A3, 4'hF, 1'b0);
        send_beat(32'hA4A5_0003, 4'hF, 1'b0);
        send_beat(32'h0000_B1B2, 4'hF, 1'b0);
        send_beat(32'hB300_0000, 4'h8, 1'b1);
        exp_q.push_back({1'b0, 4'hF, 32'hA1A2_A3A4});
        exp_q.push_back({1'b1, 4'h8, 32'hA500_0000});
        exp_q.push_back({1'b1, 4'hE, 32'hB1B2_B300});
        wait_rx(3, ok);
        total++;
        if (!ok || rx_q.size() != exp_q.size()) begin
            bad++; $display("FAIL packed_count got=%0d want=%0d", rx_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                got = {rx_q[i][36:32], rx_q[i][31:0] & keep_mask(exp_q[i][35:32])};
                total++;
                if (got !== exp_q[i]) begin
                    bad++; $display("FAIL packed_beat%0d got=%h want=%h", i, got, exp_q[i]);
                end
            end
            total++;
            if (side_q[1] !== {16'h0001, 12'd5, 7'd1, 1'b1, 1'b0}) begin
                bad++; $display("FAIL packed_side0 got=%h want=%h", side_q[1], {16'h0001, 12'd5, 7'd1, 1'b1, 1'b0});
            end
            total++;
            if (side_q[2] !== {16'h0000, 12'd3, 7'd0, 1'b0, 1'b0}) begin
                bad++; $display("FAIL packed_side1 got=%h want=%h", side_q[2], {16'h0000, 12'd3, 9'd0});
            end
        end
        total++;
        if (seq_err_n != SEQ_EN) begin
            bad++; $display("FAIL packed_seq_err got=%0d want=%0d", seq_err_n, SEQ_EN);
        end
        total++;
        if (frame_cnt !== 32'd3) begin
            bad++; $display("FAIL packed_frame_cnt got=%0d want=3", frame_cnt);
        end
    endtask

    task automatic test_backpressure();
        bit ok, stable, blocked;
        logic [36:0] got;
        logic [37:0] held;
        clear_logs();
        stable = 1'b1; blocked = 1'b0; held = '0;
        fork
            begin
                send_beat(32'h0018_0000, 4'hF, 1'b0);
                for (int b = 0; b < 6; b++)
                    send_beat({8'(4*b+1), 8'(4*b+2), 8'(4*b+3), 8'(4*b+4)}, 4'hF, b == 5);
            end
            begin
                int n = 0;
                while (rx_q.size() < 1 && n < 200) begin @(negedge clk); n++; end
                @(posedge clk); #1 m_ready = 1'b0;
                @(negedge clk);
                held = {m_valid, m_last, m_keep, m_data};
                repeat (6) begin
                    @(negedge clk);
                    if ({m_valid, m_last, m_keep, m_data} !== held) stable = 1'b0;
                    if (!s_ready) blocked = 1'b1;
                end
                @(posedge clk); #1 m_ready = 1'b1;
            end
        join
        for (int b = 0; b < 6; b++)
            exp_q.push_back({b == 5, 4'hF, 8'(4*b+1), 8'(4*b+2), 8'(4*b+3), 8'(4*b+4)});
        wait_rx(6, ok);
        total++;
        if (held[37] !== 1'b1) begin
            bad++; $display("FAIL bp_valid_during_stall got=%0b want=1", held[37]);
        end
        total++;
        if (!stable) begin
            bad++; $display("FAIL bp_hold got=changed want=stable beat %h", held);
        end
        total++;
        if (!blocked) begin
            bad++; $display("FAIL bp_tready got=never_low want=low during stall");
        end
        total++;
        if (!ok || rx_q.size() != exp_q.size()) begin
            bad++; $display("FAIL bp_count got=%0d want=%0d", rx_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                got = {rx_q[i][36:32], rx_q[i][31:0] & keep_mask(exp_q[i][35:32])};
                total++;
                if (got !== exp_q[i]) begin
                    bad++; $display("FAIL bp_beat%0d got=%h want=%h", i, got, exp_q[i]);
                end
            end
        end
        total++;
        if (frame_cnt !== 32'd4) begin
            bad++; $display("FAIL bp_frame_cnt got=%0d want=4", frame_cnt);
        end
    endtask

    task automatic test_len_err();
        bit ok;
        logic [36:0] got;
        clear_logs();
        send_beat(32'h0900_0000, 4'hF, 1'b0);
        send_beat(32'hDEAD_BEEF, 4'hF, 1'b0);
        send_beat(32'hCAFE_F00D, 4'hF, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        total++;
        if (rx_q.size() != 0) begin
            bad++; $display("FAIL lenerr_no_output got=%0d want=0", rx_q.size());
        end
        total++;
        if (err_len_n != 1) begin
            bad++; $display("FAIL lenerr_pulse got=%0d want=1", err_len_n);
        end
        send_beat(32'h0004_0000, 4'hF, 1'b0);
        send_beat(32'h1234_5678, 4'hF, 1'b1);
        exp_q.push_back({1'b1, 4'hF, 32'h1234_5678});
        wait_rx(1, ok);
        total++;
        if (!ok || rx_q.size() != 1) begin
            bad++; $display("FAIL lenerr_next_count got=%0d want=1", rx_q.size());
        end else begin
            got = {rx_q[0][36:32], rx_q[0][31:0] & keep_mask(exp_q[0][35:32])};
            total++;
            if (got !== exp_q[0] || side_q[0] !== {16'h0000, 12'd4, 9'd0}) begin
                bad++; $display("FAIL lenerr_next_beat got=%h/%h want=%h/%h", got, side_q[0], exp_q[0], {16'h0000, 12'd4, 9'd0});
            end
        end
        total++;
        if (frame_cnt !== 32'd5) begin
            bad++; $display("FAIL lenerr_frame_cnt got=%0d want=5", frame_cnt);
        end
    endtask

    task automatic test_frag_seq();
        bit ok;
        logic [36:0] got;
        clear_logs();
        send_beat(32'h0002_0001, 4'hF, 1'b0);
        send_beat(32'h00C1_C200, 4'hF, 1'b0);
        send_beat(32'h0200_0104, 4'hF, 1'b0);
        send_beat(32'hD1D2_0000, 4'hC, 1'b1);
        exp_q.push_back({1'b1, 4'hC, 32'hC1C2_0000});
        exp_q.push_back({1'b1, 4'hC, 32'hD1D2_0000});
        wait_rx(2, ok);
        total++;
        if (!ok || rx_q.size() != exp_q.size()) begin
            bad++; $display("FAIL frag_count got=%0d want=%0d", rx_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                got = {rx_q[i][36:32], rx_q[i][31:0] & keep_mask(exp_q[i][35:32])};
                total++;
                if (got !== exp_q[i]) begin
                    bad++; $display("FAIL frag_beat%0d got=%h want=%h", i, got, exp_q[i]);
                end
            end
            total++;
            if (side_q[1] !== {16'h0001, 12'd2, 7'd2, 1'b0, 1'b0}) begin
                bad++; $display("FAIL frag_side1 got=%h want=%h", side_q[1], {16'h0001, 12'd2, 7'd2, 2'b00});
            end
        end
        total++;
        if (seq_err_n != SEQ_EN) begin
            bad++; $display("FAIL frag_seq_err got=%0d want=%0d", seq_err_n, SEQ_EN);
        end
        total++;
        if (frame_cnt !== 32'd7) begin
            bad++; $display("FAIL frag_frame_cnt got=%0d want=7", frame_cnt);
        end
    endtask

    task automatic test_trunc();
        bit ok;
        logic [36:0] got;
        clear_logs();
        send_beat(32'h0008_0000, 4'hF, 1'b0);
        send_beat(32'hE1E2_E300, 4'hE, 1'b1);
        exp_q.push_back({1'b1, 4'hE, 32'hE1E2_E300});
        wait_rx(1, ok);
        total++;
        if (!ok || rx_q.size() != 1) begin
            bad++; $display("FAIL trunc_count got=%0d want=1", rx_q.size());
        end else begin
            got = {rx_q[0][36:32], rx_q[0][31:0] & keep_mask(exp_q[0][35:32])};
            total++;
            if (got !== exp_q[0]) begin
                bad++; $display("FAIL trunc_beat got=%h want=%h", got, exp_q[0]);
            end
            total++;
            if (side_q[0] !== {16'h0000, 12'd8, 7'd0, 1'b0, 1'b1}) begin
                bad++; $display("FAIL trunc_side got=%h want=%h", side_q[0], {16'h0000, 12'd8, 9'd1});
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_packed();
        test_backpressure();
        test_len_err();
        test_frag_seq();
        test_trunc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fpjh_deaggr_rx.md
Name: fpjh_deaggr_rx

Overview:
Parametrised successor to the current fragment/aggregate receive parser. It takes an aggregated super-frame on AXIS, where sub-frames are packed back-to-back at any byte offset. It splits the stream into one AXIS packet per sub-frame, realigns each payload to byte lane 0, and presents the header fields as sidebands. It sits between the receive CRC/strip stage and the reassembly buffer, and works for any bus width, with backpressure on both sides.

Parameters:
DATA_BYTES, 4, bus width in bytes (2, 4 or 8); tdata = 8*DATA_BYTES bits.
MAX_LEN, 841, largest legal payload length in bytes; larger values are errors.
LEN_W, 12, width of the length field.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous active-high
s_axis_tvalid  in  1  input beat valid
s_axis_tdata  in  8*DATA_BYTES  input data; byte 0 is the MSB byte
s_axis_tkeep  in  DATA_BYTES  contiguous from MSB; only the last beat may be partial
s_axis_tlast  in  1  end of super-frame
s_axis_tready  out  1  input ready
m_axis_tvalid  out  1  output beat valid
m_axis_tdata  out  8*DATA_BYTES  realigned payload, byte 0 = MSB
m_axis_tkeep  out  DATA_BYTES  contiguous from MSB
m_axis_tlast  out  1  last beat of sub-frame
m_axis_tready  in  1  output ready
o_type  out  16  sub-frame type; stable while the sub-frame is output
o_length  out  LEN_W  payload length of the current sub-frame
o_frag_cnt  out  7  fragment count (0 if type[0]=0)
o_frag_done  out  1  fragment-done flag (0 if type[0]=0)
o_err_trunc  out  1  on the tlast beat: sub-frame truncated by s_axis_tlast
err_len  out  1  one-cycle pulse: length 0 or > MAX_LEN
seq_err  out  1  one-cycle pulse; see Optional Feature
frame_cnt  out  32  sub-frames emitted; wraps at 2^32

Behaviour:
- Reset values: all outputs 0; state HDR; byte buffer empty.
- Sub-frame header, 4 bytes: {4'b0, len[11:8]}, len[7:0], type[15:8], type[7:0].
  - If type[0]=1, one option byte {frag_cnt[6:0], frag_done} follows.
  - Then len payload bytes follow.
- Internal byte buffer: 2*DATA_BYTES bytes, filled from byte 0.
  - s_axis_tready = 1 when free space >= DATA_BYTES and state != FLUSH_OUT.
  - In DROP, tready is always 1.
- States:
  - HDR: consume 4 bytes, then latch len and type.
    - len = 0 or len > MAX_LEN -> err_len pulse, go to DROP.
    - type[0]=1 -> OPT; otherwise -> PAY.
    - If the buffer is empty and the previous beat had tlast -> stay in HDR. Trailing bytes of fewer than 4 after the last sub-frame are discarded silently.
  - OPT: consume 1 byte, latch frag fields, -> PAY.
  - PAY: emit min(DATA_BYTES, remaining) bytes per output beat.
    - A beat is emitted only when the buffer holds that many bytes, or the input tlast has been absorbed.
    - Assert tlast when remaining reaches 0; frame_cnt += 1 on that handshake.
    - Return to HDR at the same byte offset; leftover bytes stay in the buffer.
  - FLUSH_OUT: entered when input tlast is absorbed and the buffer drains before remaining reaches 0.
    - Emit the buffered bytes with tlast=1 and o_err_trunc=1.
    - If the buffer is empty, emit one beat with tkeep=0, tlast=1, o_err_trunc=1.
    - Then -> HDR.
  - DROP: discard input until the s_axis_tlast beat, clear the buffer, -> HDR.
- Output holds tdata/tkeep/tlast/sidebands stable while tvalid && !tready.
- Latency:
  - First payload beat: 1 cycle after the byte completing the header/option is buffered, provided enough bytes are present.
  - Steady-state throughput is 1 beat/cycle when not backpressured.
- Header fields split across input beats are assembled correctly at any offset 0..DATA_BYTES-1.
- Simultaneous input push and output pop in one cycle are both honoured.
- Asynchronous rst mid-packet: immediate return to reset values. The partial packet is not completed; the first input after reset is treated as a header.

Optional Feature:
Macro FPJH_SEQ_CHECK_EN.
- Defined: track expected_cnt per fragment chain, starting at 0 and reset when a sub-frame with frag_done=1 completes.
  - An aggregated sub-frame with frag_cnt != expected_cnt pulses seq_err for 1 cycle at OPT.
  - expected_cnt then = frag_cnt+1, mod 128.
  - Data is still forwarded.
- Not defined: seq_err is tied to 0 and no tracking logic is built.

Test Plan:
1. Single non-aggregated sub-frame, DATA_BYTES=4, len=8, type=0x0000.
   - Stimulus: beats 0x00080000, 0x11223344, 0x55667788 (tlast).
   - Expected: 2 output beats, keep 0xF/0xF, tlast on the second, o_length=8, frame_cnt=1.
2. Two packed sub-frames.
   - First: len=5, type=0x0001, opt byte 0x03. Second: len=3, type=0x0000, starting at byte offset 10.
   - Expected: packets {keep 0xF, 0x8} and {keep 0xE}, realigned; o_frag_cnt=1, o_frag_done=1 on the first.
3. Backpressure: hold m_axis_tready=0 for 6 cycles mid-payload.
   - Expected: output beat held stable, s_axis_tready drops to 0 within 2 cycles, no byte lost or duplicated.
4. Length error: header len=0x900 with MAX_LEN=841.
   - Expected: err_len one pulse, input dropped to tlast, no output beat.
   - A following valid sub-frame is then parsed normally.
5. Truncation: len=8 header, s_axis_tlast after 3 payload bytes.
   - Expected: one output beat, keep 0xE, tlast=1, o_err_trunc=1.
6. Fragment sequence: aggregated sub-frames with frag_cnt 0 then 2.
   - With FPJH_SEQ_CHECK_EN: seq_err pulses once on the second.
   - Without it: seq_err stays 0.
   - Both payloads are forwarded in either case.
